// File: rtl/mdio_slave.sv
// Clause 22 MDIO responder: oversamples MDC/MDIO, decodes management frames,
// drives read data back on the falling MDC edge and strobes a local register port.
module mdio_slave #(
    parameter logic [4:0] PHY_ADDR     = 5'd1,
    parameter int         PREAMBLE_LEN = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mdc,
    input  logic        mdio_in,
    output logic        mdio_out,
    output logic        mdio_oe,
    output logic [4:0]  reg_addr,
    output logic [15:0] reg_wdata,
    output logic        reg_we,
    output logic        reg_re,
    input  logic [15:0] reg_rdata,
    output logic        busy,
    output logic        frame_err
);

    localparam logic [5:0] PRE_MAX = 6'(PREAMBLE_LEN);

    typedef enum logic [3:0] {
        IDLE, ST2, OP, PHYAD, REGAD, TA_RD, TA_RD2, RD_DATA, TA_WR, WR_DATA, IGNORE
    } state_t;

    state_t      state, state_next;
    logic        mdc_meta, mdc_sync, mdc_prev, mdio_meta, mdio_sync;
    logic        rise_stb, fall_stb;
    logic [4:0]  bit_cnt, bit_cnt_next;
    logic [5:0]  pre_cnt, pre_cnt_next;
    logic        op_msb, op_msb_next, op_rd, op_rd_next, phy_ok, phy_ok_next;
    logic [4:0]  addr_sh, addr_sh_next;
    logic [15:0] data_sh, data_sh_next;
    logic        rd_load;
    logic [4:0]  reg_addr_next;
    logic [15:0] reg_wdata_next;
    logic        reg_we_next, reg_re_next, busy_next, frame_err_next;
    logic        mdio_out_next, mdio_oe_next;
    logic [4:0]  addr_shifted;
    logic [15:0] data_shifted;

    // Two-flop synchronisers for the asynchronous management pins plus MDC history for edge detect
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mdc_meta  <= 1'b0;
            mdc_sync  <= 1'b0;
            mdc_prev  <= 1'b0;
            mdio_meta <= 1'b1;
            mdio_sync <= 1'b1;
        end else begin
            mdc_meta  <= mdc;
            mdc_sync  <= mdc_meta;
            mdc_prev  <= mdc_sync;
            mdio_meta <= mdio_in;
            mdio_sync <= mdio_meta;
        end
    end

    assign rise_stb     = mdc_sync & ~mdc_prev;
    assign fall_stb     = ~mdc_sync & mdc_prev;
    assign addr_shifted = {addr_sh[3:0], mdio_sync};
    assign data_shifted = {data_sh[14:0], mdio_sync};

    // State and frame registers; read data is captured the cycle after the read strobe
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            pre_cnt   <= '0;
            op_msb    <= 1'b0;
            op_rd     <= 1'b0;
            phy_ok    <= 1'b0;
            addr_sh   <= '0;
            data_sh   <= '0;
            rd_load   <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= '0;
            reg_we    <= 1'b0;
            reg_re    <= 1'b0;
            busy      <= 1'b0;
            frame_err <= 1'b0;
            mdio_out  <= 1'b0;
            mdio_oe   <= 1'b0;
        end else begin
            state     <= state_next;
            bit_cnt   <= bit_cnt_next;
            pre_cnt   <= pre_cnt_next;
            op_msb    <= op_msb_next;
            op_rd     <= op_rd_next;
            phy_ok    <= phy_ok_next;
            addr_sh   <= addr_sh_next;
            data_sh   <= data_sh_next;
            rd_load   <= reg_re;
            reg_addr  <= reg_addr_next;
            reg_wdata <= reg_wdata_next;
            reg_we    <= reg_we_next;
            reg_re    <= reg_re_next;
            busy      <= busy_next;
            frame_err <= frame_err_next;
            mdio_out  <= mdio_out_next;
            mdio_oe   <= mdio_oe_next;
        end
    end

    // Frame decoder: samples on rising MDC, changes the driven line on falling MDC
    always_comb begin
        state_next     = state;
        bit_cnt_next   = bit_cnt;
        pre_cnt_next   = pre_cnt;
        op_msb_next    = op_msb;
        op_rd_next     = op_rd;
        phy_ok_next    = phy_ok;
        addr_sh_next   = addr_sh;
        data_sh_next   = rd_load ? reg_rdata : data_sh;
        reg_addr_next  = reg_addr;
        reg_wdata_next = reg_wdata;
        reg_we_next    = 1'b0;
        reg_re_next    = 1'b0;
        busy_next      = busy;
        frame_err_next = 1'b0;
        mdio_out_next  = mdio_out;
        mdio_oe_next   = mdio_oe;

        case (state)
            IDLE: if (rise_stb) begin
                if (mdio_sync) begin
                    if (pre_cnt != PRE_MAX) pre_cnt_next = pre_cnt + 6'd1;
                end else if (pre_cnt == PRE_MAX) begin
                    state_next   = ST2;
                    busy_next    = 1'b1;
                    pre_cnt_next = '0;
                end else begin
                    pre_cnt_next = '0;
                end
            end
            ST2: if (rise_stb) begin
                if (mdio_sync) begin
                    state_next   = OP;
                    bit_cnt_next = '0;
                end else begin
                    state_next     = IDLE;
                    busy_next      = 1'b0;
                    frame_err_next = 1'b1;
                end
            end
            OP: if (rise_stb) begin
                if (bit_cnt == 5'd0) begin
                    op_msb_next  = mdio_sync;
                    bit_cnt_next = 5'd1;
                end else begin
                    bit_cnt_next = '0;
                    case ({op_msb, mdio_sync})
                        2'b10: begin op_rd_next = 1'b1; state_next = PHYAD; end
                        2'b01: begin op_rd_next = 1'b0; state_next = PHYAD; end
                        default: begin
                            state_next     = IDLE;
                            busy_next      = 1'b0;
                            frame_err_next = 1'b1;
                        end
                    endcase
                end
            end
            PHYAD: if (rise_stb) begin
                addr_sh_next = addr_shifted;
                if (bit_cnt == 5'd4) begin
                    phy_ok_next  = (addr_shifted == PHY_ADDR);
                    bit_cnt_next = '0;
                    state_next   = REGAD;
                end else begin
                    bit_cnt_next = bit_cnt + 5'd1;
                end
            end
            REGAD: if (rise_stb) begin
                addr_sh_next = addr_shifted;
                if (bit_cnt == 5'd4) begin
                    reg_addr_next = addr_shifted;
                    bit_cnt_next  = '0;
                    if (!phy_ok) begin
                        state_next = IGNORE;
                    end else if (op_rd) begin
                        reg_re_next = 1'b1;
                        state_next  = TA_RD;
                    end else begin
                        state_next = TA_WR;
                    end
                end else begin
                    bit_cnt_next = bit_cnt + 5'd1;
                end
            end
            IGNORE: if (rise_stb) begin
                if (bit_cnt == 5'd17) begin
                    bit_cnt_next = '0;
                    busy_next    = 1'b0;
                    state_next   = IDLE;
                end else begin
                    bit_cnt_next = bit_cnt + 5'd1;
                end
            end
            TA_RD: if (rise_stb) state_next = TA_RD2;
            TA_RD2: if (fall_stb) begin
                mdio_oe_next  = 1'b1;
                mdio_out_next = 1'b0;
                bit_cnt_next  = '0;
                state_next    = RD_DATA;
            end
            RD_DATA: if (fall_stb) begin
                if (bit_cnt == 5'd16) begin
                    mdio_oe_next  = 1'b0;
                    mdio_out_next = 1'b0;
                    busy_next     = 1'b0;
                    bit_cnt_next  = '0;
                    state_next    = IDLE;
                end else begin
                    mdio_out_next = data_sh[15];
                    data_sh_next  = {data_sh[14:0], 1'b0};
                    bit_cnt_next  = bit_cnt + 5'd1;
                end
            end
            TA_WR: if (rise_stb) begin
                if (bit_cnt == 5'd0) begin
                    bit_cnt_next = 5'd1;
                end else if (mdio_sync) begin
                    bit_cnt_next   = '0;
                    busy_next      = 1'b0;
                    frame_err_next = 1'b1;
                    state_next     = IDLE;
                end else begin
                    bit_cnt_next = '0;
                    state_next   = WR_DATA;
                end
            end
            WR_DATA: if (rise_stb) begin
                data_sh_next = data_shifted;
                if (bit_cnt == 5'd15) begin
                    reg_wdata_next = data_shifted;
                    reg_we_next    = 1'b1;
                    busy_next      = 1'b0;
                    bit_cnt_next   = '0;
                    state_next     = IDLE;
                end else begin
                    bit_cnt_next = bit_cnt + 5'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mdio_slave.sv
// Directed bench for mdio_slave: acts as the MDIO station and a register file behind the slave.
module tb_mdio_slave;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mdc = 1'b0;
    logic        drv = 1'b1;
    logic        line;
    logic        mdio_out, mdio_oe, reg_we, reg_re, busy, frame_err;
    logic [4:0]  reg_addr;
    logic [15:0] reg_wdata;
    logic [15:0] reg_rdata = 16'h0000;
    logic [15:0] rdata_val = 16'h0000;

    int n_tests = 0;
    int n_fail  = 0;

    int we_n = 0, re_n = 0, err_n = 0, oe_n = 0, busy_n = 0, excl_n = 0;
    logic [15:0] last_wdata = '0;
    logic [4:0]  last_waddr = '0, last_raddr = '0;

    mdio_slave #(.PHY_ADDR(5'd1), .PREAMBLE_LEN(32)) dut (
        .clk(clk), .reset(reset), .mdc(mdc), .mdio_in(line),
        .mdio_out(mdio_out), .mdio_oe(mdio_oe), .reg_addr(reg_addr),
        .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re),
        .reg_rdata(reg_rdata), .busy(busy), .frame_err(frame_err)
    );

    // Shared MDIO line: slave drives when enabled, otherwise the station (pull-up when released)
    assign line = mdio_oe ? mdio_out : drv;

    always #5 clk = ~clk;

    // Register file read port: data valid on the clk after the read strobe
    always @(posedge clk) if (reg_re) reg_rdata <= rdata_val;

    // Strobe and line monitor, sampled away from the active edge
    always @(negedge clk) begin
        if (!reset) begin
            if (reg_we) begin we_n++; last_wdata = reg_wdata; last_waddr = reg_addr; end
            if (reg_re) begin re_n++; last_raddr = reg_addr; end
            if (frame_err) err_n++;
            if (mdio_oe) oe_n++;
            if (busy) busy_n++;
            if ((reg_we && reg_re) || ((reg_we || reg_re) && frame_err)) excl_n++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One complete station-side frame; tail holds TA + 16 data bits (all 1s for a read = released)
    task automatic send_frame(input int pre_n, input logic [1:0] st, input logic [1:0] op,
                              input logic [4:0] phy, input logic [4:0] ra,
                              input logic [17:0] tail, input int rst_at,
                              output logic [17:0] rx);
        logic [13:0] hdr;
        hdr = {st, op, phy, ra};
        rx  = '0;
        for (int i = 0; i < pre_n; i++) begin
            mdc = 1'b0; drv = 1'b1;
            repeat (8) @(negedge clk);
            mdc = 1'b1;
            repeat (8) @(negedge clk);
        end
        for (int i = 13; i >= 0; i--) begin
            mdc = 1'b0; drv = hdr[i];
            repeat (8) @(negedge clk);
            mdc = 1'b1;
            repeat (8) @(negedge clk);
        end
        for (int i = 17; i >= 0; i--) begin
            mdc = 1'b0; drv = tail[i];
            repeat (8) @(negedge clk);
            if ((17 - i) == rst_at) begin
                check("oe_before_reset", {31'b0, mdio_oe}, 32'h1);
                reset = 1'b1;
                #1;
                check("oe_out_busy_strobes_in_reset",
                      {26'b0, mdio_oe, mdio_out, busy, reg_we, reg_re, frame_err}, 32'h0);
                check("reg_addr_in_reset", {27'b0, reg_addr}, 32'h0);
                check("reg_wdata_in_reset", {16'b0, reg_wdata}, 32'h0);
                @(negedge clk);
                reset = 1'b0;
            end
            rx[i] = line;
            mdc = 1'b1;
            repeat (8) @(negedge clk);
        end
        mdc = 1'b0; drv = 1'b1;
        repeat (16) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [17:0] rx;
        int we0, re0, err0, oe0, busy0;

        repeat (4) @(negedge clk);
        check("reset_outputs", {26'b0, mdio_oe, mdio_out, busy, reg_we, reg_re, frame_err}, 32'h0);
        check("reset_regs", {11'b0, reg_addr, reg_wdata}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // 1: write 0xA5C3 to reg 0x05
        we0 = we_n; oe0 = oe_n;
        send_frame(32, 2'b01, 2'b01, 5'd1, 5'h05, {2'b10, 16'hA5C3}, -1, rx);
        check("t1_we_count", we_n - we0, 1);
        check("t1_waddr", {27'b0, last_waddr}, 32'h05);
        check("t1_wdata", {16'b0, last_wdata}, 32'hA5C3);
        check("t1_oe_never", oe_n - oe0, 0);
        check("t1_busy_after", {31'b0, busy}, 0);

        // 2: read 0x8001 from reg 0x1F
        rdata_val = 16'h8001; re0 = re_n; oe0 = oe_n;
        send_frame(32, 2'b01, 2'b10, 5'd1, 5'h1F, 18'h3FFFF, -1, rx);
        check("t2_re_count", re_n - re0, 1);
        check("t2_raddr", {27'b0, last_raddr}, 32'h1F);
        check("t2_ta_line", {30'b0, rx[17:16]}, 32'h2);
        check("t2_rdata", {16'b0, rx[15:0]}, 32'h8001);
        check("t2_oe_used", {31'b0, (oe_n - oe0) > 0}, 1);
        check("t2_oe_released", {30'b0, mdio_oe, busy}, 0);

        // 3: only 31 preamble ones
        we0 = we_n; busy0 = busy_n; err0 = err_n;
        send_frame(31, 2'b01, 2'b01, 5'd1, 5'h05, {2'b10, 16'h1111}, -1, rx);
        check("t3_no_we", we_n - we0, 0);
        check("t3_no_busy", busy_n - busy0, 0);
        check("t3_no_err", err_n - err0, 0);

        // 4: bad start, bad opcode, then a good write
        err0 = err_n; we0 = we_n;
        send_frame(32, 2'b00, 2'b01, 5'd1, 5'h02, {2'b10, 16'h0000}, -1, rx);
        check("t4_st_err", err_n - err0, 1);
        check("t4_st_busy", {31'b0, busy}, 0);
        send_frame(32, 2'b01, 2'b11, 5'd1, 5'h02, {2'b10, 16'h0000}, -1, rx);
        check("t4_op_err", err_n - err0, 2);
        send_frame(32, 2'b01, 2'b01, 5'd1, 5'h02, {2'b10, 16'h1234}, -1, rx);
        check("t4_we_count", we_n - we0, 1);
        check("t4_wdata", {16'b0, last_wdata}, 32'h1234);
        check("t4_waddr", {27'b0, last_waddr}, 32'h02);
        check("t4_err_total", err_n - err0, 2);

        // 4b: write with TA bit 2 = 1 is rejected
        err0 = err_n; we0 = we_n;
        send_frame(32, 2'b01, 2'b01, 5'd1, 5'h03, {2'b11, 16'h0F0F}, -1, rx);
        check("t4b_ta_err", err_n - err0, 1);
        check("t4b_no_we", we_n - we0, 0);

        // 5: read to another PHY, then a read to ours
        rdata_val = 16'h5A5A; re0 = re_n; oe0 = oe_n; err0 = err_n;
        send_frame(32, 2'b01, 2'b10, 5'h07, 5'h04, 18'h3FFFF, -1, rx);
        check("t5_no_oe", oe_n - oe0, 0);
        check("t5_no_re", re_n - re0, 0);
        check("t5_no_err", err_n - err0, 0);
        check("t5_idle_after", {31'b0, busy}, 0);
        send_frame(32, 2'b01, 2'b10, 5'd1, 5'h04, 18'h3FFFF, -1, rx);
        check("t5_re_count", re_n - re0, 1);
        check("t5_rdata", {16'b0, rx[15:0]}, 32'h5A5A);

        // 6: reset during read data bit 8, then a full read
        rdata_val = 16'hBEEF; we0 = we_n; err0 = err_n;
        send_frame(32, 2'b01, 2'b10, 5'd1, 5'h0A, 18'h3FFFF, 10, rx);
        check("t6_no_we", we_n - we0, 0);
        check("t6_no_err", err_n - err0, 0);
        re0 = re_n;
        send_frame(32, 2'b01, 2'b10, 5'd1, 5'h0A, 18'h3FFFF, -1, rx);
        check("t6_re_count", re_n - re0, 1);
        check("t6_raddr", {27'b0, last_raddr}, 32'h0A);
        check("t6_rdata", {16'b0, rx[15:0]}, 32'hBEEF);
        check("t6_oe_released", {31'b0, mdio_oe}, 0);

        check("strobe_exclusive", excl_n, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
